ebpf_alu_exec: RTL

Multi-cycle eBPF ALU/ALU64 execute unit. It is the initiator side of the core's GPR file: it accepts one decoded 64-bit eBPF instruction, drives the register-file dst/src indices, and consumes the combinational read data and the 2-bit register exception. It computes the result and issues a single write-back. Sits between instruction fetch/decode and the register file; one instruction in flight.

---
 rtl/ebpf_exec_pkg.sv | 28 ++
 rtl/ebpf_serial_div.sv | 40 ++++
 rtl/ebpf_alu_exec.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ebpf_exec_pkg.sv
// ebpf_exec_pkg: shared encodings for the eBPF ALU execute unit
package ebpf_exec_pkg;
  localparam logic [2:0] CLS_ALU = 3'h4;
  localparam logic [2:0] CLS_ALU64 = 3'h7;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_OR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LSH = 4'h6;
  localparam logic [3:0] OP_RSH = 4'h7;
  localparam logic [3:0] OP_NEG = 4'h8;
  localparam logic [3:0] OP_MOD = 4'h9;
  localparam logic [3:0] OP_XOR = 4'ha;
  localparam logic [3:0] OP_MOV = 4'hb;
  localparam logic [3:0] OP_ARSH = 4'hc;
  localparam int SRC_BIT = 3;
  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_INVALID_DST = 3'd1;
  localparam logic [2:0] EXC_INVALID_SRC = 3'd2;
  localparam logic [2:0] EXC_ILLEGAL_OP = 3'd3;
  localparam logic [2:0] EXC_DIV_ZERO = 3'd4;
  localparam logic [1:0] RF_EXC_NONE = 2'd0;
  localparam logic [1:0] RF_EXC_INVALID_DST = 2'd1;
  localparam logic [1:0] RF_EXC_INVALID_SRC = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_DIV, S_WB} state_t;
endpackage

// File: rtl/ebpf_serial_div.sv
// ebpf_serial_div: unsigned restoring divider, one quotient bit per cycle, 32- or 64-bit
module ebpf_serial_div
  import ebpf_exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        w64,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        done,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);
  logic [63:0] quo, rem, dvs;
  logic [6:0] cnt;
  logic [64:0] trial, diff;
  assign trial = {rem, quo[63]};
  assign diff = trial - {1'b0, dvs};
  assign done = cnt == 7'd1;
  assign quotient = quo;
  assign remainder = rem;
  // 32-bit operands are left-aligned so the MSB always shifts out of bit 63
  always_ff @(posedge clk)
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      quo <= w64 ? dividend : {dividend[31:0], 32'b0};
      rem <= '0;
      dvs <= w64 ? divisor : {32'b0, divisor[31:0]};
      cnt <= w64 ? 7'd64 : 7'd32;
    end else if (cnt != 7'd0) begin
      rem <= diff[64] ? trial[63:0] : diff[63:0];
      quo <= {quo[62:0], ~diff[64]};
      cnt <= cnt - 7'd1;
    end
endmodule

// File: rtl/ebpf_alu_exec.sv
// ebpf_alu_exec: multi-cycle eBPF ALU/ALU64 execute unit driving the GPR file read/write ports
module ebpf_alu_exec
  import ebpf_exec_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit ZERO_DIV_FAULT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            insn_valid,
  output logic            insn_ready,
  input  logic [63:0]     insn,
  output logic [3:0]      rf_dst,
  output logic [3:0]      rf_src,
  input  logic [XLEN-1:0] rf_dst_rdata,
  input  logic [XLEN-1:0] rf_src_rdata,
  input  logic [1:0]      rf_exc,
  output logic [XLEN-1:0] rf_wdata,
  output logic            rf_we,
  output logic            done_valid,
  output logic [2:0]      done_exc,
  output logic            busy
);
  state_t state;
  logic [7:0] opc;
  logic [3:0] dst, src, op;
  logic [31:0] imm;
  logic [XLEN-1:0] dst_q, src_q, res_q, a, b_full, b, raw, exec_res, quo, rem;
  logic signed [XLEN-1:0] ars64;
  logic signed [31:0] ars32;
  logic [1:0] rexc_q;
  logic [2:0] exc_q, exec_exc, cls;
  logic [5:0] sh;
  logic div_q, w64, srcx, legal, is_div, bz, go_div, div_done, wb, unused_off;
  assign unused_off = ^insn[31:16];
  assign cls = opc[2:0];
  assign op = opc[7:4];
  assign srcx = opc[SRC_BIT];
  assign w64 = cls == CLS_ALU64;
  assign legal = (cls == CLS_ALU || w64) && op <= OP_ARSH;
  assign a = w64 ? dst_q : {32'b0, dst_q[31:0]};
  assign b_full = srcx ? src_q : {{32{imm[31]}}, imm};
  assign b = w64 ? b_full : {32'b0, b_full[31:0]};
  assign sh = w64 ? b[5:0] : {1'b0, b[4:0]};
  assign ars64 = $signed(a) >>> sh;
  assign ars32 = $signed(a[31:0]) >>> sh;
  assign is_div = op == OP_DIV || op == OP_MOD;
  assign bz = b == '0;
  // DIV/MOD only reach this mux for a zero divisor; nonzero divisors go through the serial divider
  always_comb begin
    case (op)
      OP_ADD:  raw = a + b;
      OP_SUB:  raw = a - b;
      OP_MUL:  raw = a * b;
      OP_DIV:  raw = '0;
      OP_OR:   raw = a | b;
      OP_AND:  raw = a & b;
      OP_LSH:  raw = a << sh;
      OP_RSH:  raw = a >> sh;
      OP_NEG:  raw = -a;
      OP_MOD:  raw = a;
      OP_XOR:  raw = a ^ b;
      OP_MOV:  raw = b;
      OP_ARSH: raw = w64 ? ars64 : {32'b0, ars32};
      default: raw = '0;
    endcase
  end
  assign exec_res = w64 ? raw : {32'b0, raw[31:0]};
  assign exec_exc = rexc_q == RF_EXC_INVALID_DST ? EXC_INVALID_DST :
                    rexc_q == RF_EXC_INVALID_SRC && srcx && op != OP_NEG ? EXC_INVALID_SRC :
                    is_div && bz && ZERO_DIV_FAULT ? EXC_DIV_ZERO : EXC_NONE;
  assign go_div = exec_exc == EXC_NONE && is_div && !bz;
  assign insn_ready = state == S_IDLE && !reset;
  assign busy = state != S_IDLE;
  assign rf_dst = busy ? dst : '0;
  assign rf_src = busy ? src : '0;
  assign wb = state == S_WB && !reset;
  assign rf_we = wb && exc_q == EXC_NONE;
  assign done_valid = wb;
  assign done_exc = wb ? exc_q : EXC_NONE;
  assign rf_wdata = div_q ? (op == OP_MOD ? rem : quo) : res_q;
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      opc <= '0;
      dst <= '0;
      src <= '0;
      imm <= '0;
      dst_q <= '0;
      src_q <= '0;
      rexc_q <= RF_EXC_NONE;
      exc_q <= EXC_NONE;
      res_q <= '0;
      div_q <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (insn_valid) begin
            opc <= insn[7:0];
            dst <= insn[11:8];
            src <= insn[15:12];
            imm <= insn[63:32];
            div_q <= 1'b0;
            state <= S_READ;
          end
        S_READ: begin
          dst_q <= rf_dst_rdata;
          src_q <= rf_src_rdata;
          rexc_q <= rf_exc;
          exc_q <= legal ? EXC_NONE : EXC_ILLEGAL_OP;
          state <= legal ? S_EXEC : S_WB;
        end
        S_EXEC: begin
          exc_q <= exec_exc;
          res_q <= exec_res;
          div_q <= go_div;
          state <= go_div ? S_DIV : S_WB;
        end
        S_DIV: state <= div_done ? S_WB : S_DIV;
        S_WB: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
  ebpf_serial_div u_div (
    .clk(clk),
    .reset(reset),
    .start(state == S_EXEC && go_div),
    .w64(w64),
    .dividend(a),
    .divisor(b),
    .done(div_done),
    .quotient(quo),
    .remainder(rem)
  );
endmodule
